// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_if
// Description : Column drive, row sense and key report bundle for the 4x4 keypad
//               scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_if;
   logic [3:0] row;
   logic [3:0] col;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   modport master (
      input  row,
      output col,
      output key_valid,
      output key_code,
      output key_held
   );

   modport slave (
      output row,
      input  col,
      input  key_valid,
      input  key_code,
      input  key_held
   );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : 4x4 keypad column scanner that locks onto one key, debounces
//               press and release, and strobes the key index once per press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
   parameter int SETTLE_CYCLES   = 4,
   parameter int DEBOUNCE_CYCLES = 60
) (
   input  logic          clk,
   input  logic          nrst,
   keypad_scan_if.master kp
);

   localparam int c_cnt_max = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                              (SETTLE_CYCLES - 1) : (DEBOUNCE_CYCLES - 1);
   localparam int c_cnt_w   = (c_cnt_max < 2) ? 1 : $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_deb_last    = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   if (SETTLE_CYCLES < 1) begin : g_settle_chk
      $error("SETTLE_CYCLES must be >= 1");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_deb_chk
      $error("DEBOUNCE_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESS    = 2'd2,
      ST_HOLD     = 2'd3
   } state_t;

   state_t               r_state,     w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt,       w_cnt_nxt;
   logic [1:0]           r_col_idx,   w_col_idx_nxt;
   logic [1:0]           r_row_sel,   w_row_sel_nxt;
   logic [3:0]           r_col,       w_col_nxt;
   logic                 r_key_valid, w_key_valid_nxt;
   logic [3:0]           r_key_code,  w_key_code_nxt;
   logic                 r_key_held,  w_key_held_nxt;

   logic [1:0]           w_first_row;
   logic                 w_row_bit;

   // Lowest-index closed row wins when several rows are seen at once.
   always_comb begin
      w_first_row = 2'd0;
      if (kp.row[0]) begin
         w_first_row = 2'd0;
      end else if (kp.row[1]) begin
         w_first_row = 2'd1;
      end else if (kp.row[2]) begin
         w_first_row = 2'd2;
      end else begin
         w_first_row = 2'd3;
      end
   end

   assign w_row_bit = kp.row[r_row_sel];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state     <= ST_SCAN;
         r_cnt       <= '0;
         r_col_idx   <= 2'd0;
         r_row_sel   <= 2'd0;
         r_col       <= 4'b0001;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_col_idx   <= w_col_idx_nxt;
         r_row_sel   <= w_row_sel_nxt;
         r_col       <= w_col_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_key_code  <= w_key_code_nxt;
         r_key_held  <= w_key_held_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_col_idx_nxt   = r_col_idx;
      w_row_sel_nxt   = r_row_sel;
      w_key_valid_nxt = 1'b0;
      w_key_code_nxt  = r_key_code;
      w_key_held_nxt  = r_key_held;

      case (r_state)
         ST_SCAN: begin
            if (r_cnt == c_settle_last) begin
               w_cnt_nxt = '0;
               if (kp.row == 4'd0) begin
                  w_col_idx_nxt = r_col_idx + 2'd1;
               end else begin
                  w_row_sel_nxt = w_first_row;
                  w_state_nxt   = ST_DEBOUNCE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ST_DEBOUNCE: begin
            if (!w_row_bit) begin
               // Column stays put so the same key gets a fresh settle window.
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SCAN;
            end else if (r_cnt == c_deb_last) begin
               w_cnt_nxt       = '0;
               w_state_nxt     = ST_PRESS;
               w_key_valid_nxt = 1'b1;
               w_key_code_nxt  = {r_row_sel, r_col_idx};
               w_key_held_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ST_PRESS: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HOLD;
         end

         ST_HOLD: begin
            if (w_row_bit) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == c_deb_last) begin
               // Resume at the next column so other held keys get their turn.
               w_cnt_nxt      = '0;
               w_key_held_nxt = 1'b0;
               w_col_idx_nxt  = r_col_idx + 2'd1;
               w_state_nxt    = ST_SCAN;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SCAN;
         end
      endcase

      w_col_nxt = 4'b0001 << w_col_idx_nxt;
   end

   assign kp.col       = r_col;
   assign kp.key_valid = r_key_valid;
   assign kp.key_code  = r_key_code;
   assign kp.key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_ctrl
// Description : Directed bench for keypad_scan_ctrl with a key-matrix model and
//               a strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;
   localparam int SETTLE = 4;
   localparam int DEB    = 8;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;

   logic       clk  = 1'b0;
   logic       nrst = 1'b0;
   logic [15:0] keys = '0;
   int         cyc      = 0;
   int         checks   = 0;
   int         failures = 0;
   exp_t       exp_q[$];
   int         k;
   int         r;

   keypad_scan_if kp_if();

   keypad_scan_ctrl #(
      .SETTLE_CYCLES   (SETTLE),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .kp   (kp_if.master)
   );

   // Key (row r, column c) is bit r*4+c; a closed key shorts its column to its row.
   assign kp_if.row = {|(keys[15:12] & kp_if.col), |(keys[11:8] & kp_if.col),
                       |(keys[7:4]   & kp_if.col), |(keys[3:0]  & kp_if.col)};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic step_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Returns at the first cycle in which col newly equals c.
   task automatic wait_col(input logic [3:0] c, output int kc);
      int n = 0;
      while (kp_if.col == c && n < 64) begin step(); n++; end
      while (kp_if.col != c && n < 64) begin step(); n++; end
      if (n >= 64) chk("wait_col_timeout", {28'd0, kp_if.col}, {28'd0, c});
      kc = cyc;
   endtask

   task automatic push_exp(input logic [3:0] code, input int at);
      exp_t e;
      e.code = code;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic release_key(input logic [3:0] next_col, input logic [3:0] code);
      keys = '0;
      repeat (DEB - 1) step();
      chk("held_before_release_done", {31'd0, kp_if.key_held}, 32'd1);
      chk("code_kept_in_hold", {28'd0, kp_if.key_code}, {28'd0, code});
      step();
      chk("held_after_release", {31'd0, kp_if.key_held}, 32'd0);
      chk("col_after_release", {28'd0, kp_if.col}, {28'd0, next_col});
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (kp_if.key_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_strobe: key_code=%h at cycle %0d, no strobe expected",
                           kp_if.key_code, cyc);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("strobe_code", {28'd0, kp_if.key_code}, {28'd0, e.code});
                  chk("strobe_cycle", cyc, e.cyc);
                  chk("held_at_strobe", {31'd0, kp_if.key_held}, 32'd1);
               end
            end
         end
      join_none

      // Reset values, then idle column rotation
      repeat (3) step();
      chk("rst_col", {28'd0, kp_if.col}, 32'h1);
      chk("rst_valid", {31'd0, kp_if.key_valid}, 32'd0);
      chk("rst_code", {28'd0, kp_if.key_code}, 32'd0);
      chk("rst_held", {31'd0, kp_if.key_held}, 32'd0);
      nrst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("idle_col", {28'd0, kp_if.col}, {28'd0, 4'b0001 << ((i / SETTLE) % 4)});
         step();
      end
      chk("idle_held", {31'd0, kp_if.key_held}, 32'd0);

      // Clean press of row 2, column 1
      wait_col(4'b0010, k);
      keys[9] = 1'b1;
      push_exp(4'b1001, k + SETTLE + DEB);
      step_to(k + 40);
      release_key(4'b0100, 4'b1001);

      // Bouncy press of row 2, column 0
      wait_col(4'b0001, k);
      keys[8] = 1'b1;
      push_exp(4'b1000, k + 28);
      step_to(k + 7);  keys[8] = 1'b0;
      step_to(k + 8);  keys[8] = 1'b1;
      chk("bounce1_same_col", {28'd0, kp_if.col}, 32'h1);
      step_to(k + 15); keys[8] = 1'b0;
      step_to(k + 16); keys[8] = 1'b1;
      chk("bounce2_same_col", {28'd0, kp_if.col}, 32'h1);
      step_to(k + 40);
      release_key(4'b0010, 4'b1000);

      // Rows 1 and 3 in column 3; row 3 dropped mid-debounce, then re-held
      wait_col(4'b1000, k);
      keys[7]  = 1'b1;
      keys[15] = 1'b1;
      push_exp(4'b0111, k + SETTLE + DEB);
      step_to(k + 6);  keys[15] = 1'b0;
      step_to(k + 20); keys[15] = 1'b1;
      step_to(k + 24);
      r = cyc;
      keys[7] = 1'b0;
      push_exp(4'b1111, r + DEB + 3 * SETTLE + SETTLE + DEB);
      step_to(r + 7);
      chk("multi_held_pre", {31'd0, kp_if.key_held}, 32'd1);
      step_to(r + 8);
      chk("multi_held_post", {31'd0, kp_if.key_held}, 32'd0);
      chk("multi_next_col", {28'd0, kp_if.col}, 32'h1);
      step_to(r + 40);
      release_key(4'b0001, 4'b1111);

      // Release bounce: low 5, high 1, low 8
      wait_col(4'b0100, k);
      keys[2] = 1'b1;
      push_exp(4'b0010, k + SETTLE + DEB);
      step_to(k + 20);
      r = cyc;
      keys[2] = 1'b0;
      step_to(r + 5); keys[2] = 1'b1;
      step_to(r + 6); keys[2] = 1'b0;
      step_to(r + 13);
      chk("relbounce_held_pre", {31'd0, kp_if.key_held}, 32'd1);
      step_to(r + 14);
      chk("relbounce_held_post", {31'd0, kp_if.key_held}, 32'd0);
      chk("relbounce_col", {28'd0, kp_if.col}, 32'h8);

      // Reset during DEBOUNCE, then during HOLD
      wait_col(4'b0010, k);
      keys[5] = 1'b1;
      step_to(k + 6);
      nrst = 1'b0;
      step();
      chk("deb_rst_col", {28'd0, kp_if.col}, 32'h1);
      chk("deb_rst_held", {31'd0, kp_if.key_held}, 32'd0);
      chk("deb_rst_code", {28'd0, kp_if.key_code}, 32'd0);
      chk("deb_rst_valid", {31'd0, kp_if.key_valid}, 32'd0);
      nrst = 1'b1;
      push_exp(4'b0101, k + 7 + SETTLE + SETTLE + DEB);
      step_to(k + 32);
      chk("hold_before_rst", {31'd0, kp_if.key_held}, 32'd1);
      nrst = 1'b0;
      step();
      chk("hold_rst_col", {28'd0, kp_if.col}, 32'h1);
      chk("hold_rst_held", {31'd0, kp_if.key_held}, 32'd0);
      chk("hold_rst_code", {28'd0, kp_if.key_code}, 32'd0);
      chk("hold_rst_valid", {31'd0, kp_if.key_valid}, 32'd0);
      nrst = 1'b1;
      keys = '0;
      repeat (20) step();

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. It drives one column at a time and samples the four synchronized row inputs. When a key is found, it holds the scan on that key, debounces the press and then the release, and reports each press once as a one-cycle strobe with a 4-bit key index. It sits between the two-flop row synchronizers and the key-decode/display logic. It replaces free-running per-row debouncing with a single sequenced debounce of the one captured key.

## Interface
- SETTLE_CYCLES, default 4: cycles each column is driven before rows are sampled; must be >= 1.
- DEBOUNCE_CYCLES, default 60: consecutive stable cycles required to accept a press or a release; must be >= 2.
- clk  input  1  system clock.
- nrst  input  1  reset, synchronous, active-low.
- row  input  4  synchronized row levels, active-high (1 = key closed in the driven column).
- col  output  4  column drive, one-hot, active-high.
- key_valid  output  1  one-cycle strobe per accepted press.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted press.
- key_held  output  1  high from the press strobe until the release is accepted.

## Operation
- All outputs are registered. One counter, `cnt`, is sized to hold max(SETTLE_CYCLES, DEBOUNCE_CYCLES) - 1. Index registers: `col_idx` (2 bits) and `row_sel` (2 bits).
- Reset values: state SCAN, col = 4'b0001, col_idx = 0, cnt = 0, key_valid = 0, key_code = 0, key_held = 0, row_sel = 0.
- SCAN:
  - cnt counts 0..SETTLE_CYCLES-1 with the column driven.
  - At cnt == SETTLE_CYCLES-1, if row == 0: col_idx increments mod 4 (3 wraps to 0), col rotates left accordingly, cnt = 0.
  - At cnt == SETTLE_CYCLES-1, if row != 0: row_sel is set to the lowest-index set bit, cnt = 0, go to DEBOUNCE. The column does not change.
  - If row changes before the sample cycle, the change is ignored; rows are evaluated only at the sample cycle.
- DEBOUNCE: only row[row_sel] is monitored; other row bits are ignored.
  - row[row_sel] == 0: go to SCAN with the same column, cnt = 0 (full settle repeated).
  - row[row_sel] == 1 and cnt == DEBOUNCE_CYCLES-1: go to PRESS.
  - Otherwise cnt increments.
- PRESS: lasts exactly one cycle.
  - key_valid = 1 and key_code = {row_sel, col_idx}.
  - key_held is set to 1.
  - cnt = 0, go to HOLD.
- HOLD:
  - row[row_sel] == 1: cnt = 0.
  - row[row_sel] == 0: cnt increments.
  - When row[row_sel] == 0 and cnt == DEBOUNCE_CYCLES-1: key_held = 0, advance to the next column (mod 4), cnt = 0, go to SCAN.
  - A bounce high during release restarts the release count.
- Other keys are not reported while a key is held. Because the scan resumes at the next column, a second simultaneously held key is found on a later pass.
- key_code holds its value until the next PRESS. key_valid is 0 in every state except PRESS.
- nrst low in any state, including mid-debounce or mid-hold, returns everything to the reset values on the next edge. No strobe is emitted.
- Illegal state encodings go to SCAN.

## Timing
- Column dwell in SCAN with no key: SETTLE_CYCLES cycles. Full empty scan: 4*SETTLE_CYCLES cycles.
- Press latency: with the sample edge at cycle t (last settle cycle), DEBOUNCE occupies t+1..t+DEBOUNCE_CYCLES and key_valid is high in cycle t+DEBOUNCE_CYCLES+1.
- Release latency: key_held falls DEBOUNCE_CYCLES cycles after the first of the consecutive low cycles on row[row_sel]. The new column is driven in that same cycle.
- Throughput: at most one key_valid per press/release pair.

## Test plan
Run the bench with SETTLE_CYCLES=4 and DEBOUNCE_CYCLES=8.
- Reset then idle, row=0: col cycles 0001→0010→0100→1000→0001, 4 cycles each. key_valid never asserts. key_code=0 and key_held=0.
- Clean press of row 2 while col=0010, held 40 cycles then released: exactly one key_valid, with key_code=4'b1001, exactly 9 cycles after the sample edge. key_held falls 8 cycles after release, then col=0100.
- Bouncy press, row[2] toggles high 3 cycles / low 1 cycle twice, then stable: no strobe during the bounces. Each low returns to SCAN on the same column. Exactly one strobe after 8 stable cycles.
- Rows 1 and 3 both high at the sample with col=1000: key_code=4'b0111. Dropping row 3 mid-debounce has no effect. After release of row 1, a later scan reports 4'b1111 if row 3 is still held.
- Release bounce: in HOLD, row low 5 cycles, high 1, low 8: key_held stays 1 until the 8th cycle of the final low run. No extra strobe.
- nrst low for 1 cycle during DEBOUNCE and again during HOLD: the next cycle shows col=0001, key_held=0, key_code=0 and no key_valid.
